// File: rtl/mem_access_ctrl_if.sv
// Memory-side request/response bus of mem_access_ctrl.
// master: the access controller (drives the request payload).
// slave:  the memory (drives ready and the read response).
interface mem_access_ctrl_if;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns a core load/store request into one memory bus
// transaction and returns a single-cycle completion pulse.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access that
// waits TIMEOUT_CYCLES cycles in REQ or WAIT_R (completes with rsp_err=1).
// Without it rsp_err is tied low and the controller waits indefinitely.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16  // legal range 2..255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [3:0]         req_wmask,
    output logic               stall,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    mem_access_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } state_t;

    state_t state;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Cycles spent in the current REQ or WAIT_R visit.
    logic [7:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // The core is held until the DONE cycle; the request it shows in the
    // following IDLE cycle is the next instruction's access.
    assign stall = req_valid && (state != DONE);

    // Controller FSM with registered bus payload and response outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_wmask <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            rsp_err       <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            // NOTE: rsp_valid defaults low every cycle so it is a one-cycle
            // pulse set only on the edge that enters DONE.
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        state         <= REQ;
                        bus.bus_valid <= 1'b1;
                        bus.bus_we    <= req_we;
                        bus.bus_addr  <= {req_addr[31:2], 2'b00};
                        bus.bus_wdata <= req_wdata;
                        bus.bus_wmask <= req_we ? req_wmask : 4'h0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                REQ: begin
                    // A handshake on the limit cycle takes priority over timeout.
                    if (bus.bus_ready) begin
                        bus.bus_valid <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                        if (bus.bus_we) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        bus.bus_valid <= 1'b0;
                        state         <= DONE;
                        rsp_valid     <= 1'b1;
                        rsp_err       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                WAIT_R: begin
                    if (bus.bus_rvalid) begin
                        rsp_rdata <= bus.bus_rdata;
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    rsp_err <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a scripted core driver, a
// configurable memory model and a negedge monitor that compares bus
// transactions and responses against scoreboard queues.
module tb_mem_access_ctrl;

    localparam int unsigned TO_CYCLES  = 4;
    localparam int          WAIT_LIMIT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } bus_txn_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    bus_txn_t    exp_bus_q[$];
    rsp_t        exp_rsp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_bus  = 0;
    int          n_rsp  = 0;
    logic [31:0] model_rdata = '0;

    // Memory model configuration, set by the core driver per access.
    int          cfg_ready_wait  = 0;
    int          cfg_rvalid_wait = 0;
    logic [31:0] cfg_rdata       = '0;
    int          stray_rvalid    = 0;

    // Memory model: ready after cfg_ready_wait valid cycles, read data
    // cfg_rvalid_wait cycles after a load handshake. A pending read is not
    // cancelled by controller reset, so it can arrive late.
    initial begin : mem_model
        bit          hs;
        bit          hs_load;
        bit          rd_pending;
        int          valid_cnt;
        int          rd_cnt;
        logic [31:0] rd_data;
        rd_pending = 1'b0;
        valid_cnt  = 0;
        rd_cnt     = 0;
        rd_data    = '0;
        bus.bus_ready  = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata  = '1;
        forever begin
            @(negedge clk);
            hs      = bus.bus_valid && bus.bus_ready;
            hs_load = hs && !bus.bus_we;
            @(posedge clk);
            #1;
            bus.bus_ready  = 1'b0;
            bus.bus_rvalid = 1'b0;
            bus.bus_rdata  = 32'hFFFF_FFFF;
            if (hs_load) begin
                rd_pending = 1'b1;
                rd_cnt     = 0;
                rd_data    = cfg_rdata;
            end
            if (rd_pending) begin
                if (rd_cnt >= cfg_rvalid_wait) begin
                    bus.bus_rvalid = 1'b1;
                    bus.bus_rdata  = rd_data;
                    rd_pending     = 1'b0;
                end else begin
                    rd_cnt++;
                end
            end
            if (stray_rvalid > 0) begin
                bus.bus_rvalid = 1'b1;
                bus.bus_rdata  = 32'hDEAD_0000 + 32'(stray_rvalid);
                stray_rvalid--;
            end
            if (!bus.bus_valid || hs) valid_cnt = 0;
            if (bus.bus_valid) begin
                if (valid_cnt >= cfg_ready_wait) bus.bus_ready = 1'b1;
                else valid_cnt++;
            end
        end
    end

    // Monitor: payload stability, bus transactions and responses.
    bit       prev_wait = 1'b0;
    bus_txn_t prev_txn;
    bus_txn_t got_b;
    bus_txn_t exp_b;
    rsp_t     got_r;
    rsp_t     exp_r;

    always @(negedge clk) begin
        got_b = {bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_wmask};
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
`ifndef MEM_ACCESS_TIMEOUT_EN
                checks++;
                if (bus.bus_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_hold: bus_valid=%b before ready, required 1", bus.bus_valid);
                end
`endif
                if (bus.bus_valid === 1'b1) begin
                    checks++;
                    if (got_b !== prev_txn) begin
                        errors++;
                        $display("FAIL payload_stable: got %h, required %h", got_b, prev_txn);
                    end
                end
            end
            prev_wait = (bus.bus_valid === 1'b1) && (bus.bus_ready !== 1'b1);
            prev_txn  = got_b;

            if (bus.bus_valid === 1'b1 && bus.bus_ready === 1'b1) begin
                n_bus++;
                checks++;
                if (exp_bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_txn_unexpected: got we=%b addr=%h wdata=%h wmask=%b, required none",
                             got_b.we, got_b.addr, got_b.wdata, got_b.wmask);
                end else begin
                    exp_b = exp_bus_q.pop_front();
                    if (got_b !== exp_b) begin
                        errors++;
                        $display("FAIL bus_txn: got we=%b addr=%h wdata=%h wmask=%b, required we=%b addr=%h wdata=%h wmask=%b",
                                 got_b.we, got_b.addr, got_b.wdata, got_b.wmask,
                                 exp_b.we, exp_b.addr, exp_b.wdata, exp_b.wmask);
                    end
                end
            end

            if (rsp_valid === 1'b1) begin
                n_rsp++;
                got_r = {rsp_rdata, rsp_err};
                checks++;
                if (exp_rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response",
                             got_r.rdata, got_r.err);
                end else begin
                    exp_r = exp_rsp_q.pop_front();
                    if (got_r !== exp_r) begin
                        errors++;
                        $display("FAIL rsp: got rdata=%h err=%b, required rdata=%h err=%b",
                                 got_r.rdata, got_r.err, exp_r.rdata, exp_r.err);
                    end
                end
            end
        end
    end

    // Core driver: presents one access from posedge+1, pushes the expected
    // bus transaction/response, and returns at posedge+1 after the DONE cycle
    // with req_valid still high. lat counts cycles from request to rsp_valid.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input int ready_wait, input int rvalid_wait,
                         input logic [31:0] rdata, input bit expect_bus, input bit expect_err,
                         output int lat);
        bus_txn_t eb;
        rsp_t     er;
        bit       got;
        bit       stall_bad;
        int       cyc;
        cfg_ready_wait  = ready_wait;
        cfg_rvalid_wait = rvalid_wait;
        cfg_rdata       = rdata;
        if (expect_bus) begin
            eb.we    = we;
            eb.addr  = {addr[31:2], 2'b00};
            eb.wdata = wdata;
            eb.wmask = we ? wmask : 4'h0;
            exp_bus_q.push_back(eb);
        end
        if (!we && !expect_err) model_rdata = rdata;
        er.rdata = model_rdata;
        er.err   = expect_err;
        exp_rsp_q.push_back(er);

        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        got       = 1'b0;
        stall_bad = 1'b0;
        cyc       = 0;
        while (!got && cyc < WAIT_LIMIT) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                if (stall !== 1'b0) stall_bad = 1'b1;
            end else if (stall !== 1'b1) begin
                stall_bad = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        lat = cyc;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles (addr=%h)", WAIT_LIMIT, addr);
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("FAIL stall_profile: stall not high-until-DONE/low-in-DONE (addr=%h)", addr);
        end
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_lat(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: latency %0d cycles, required %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0FFF;
        req_wdata = 32'h1234_5678;
        req_wmask = 4'hF;
        #1;
        checks++;
        if ({bus.bus_valid, rsp_valid, rsp_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: bus_valid/rsp_valid/rsp_err=%b, required 000",
                     {bus.bus_valid, rsp_valid, rsp_err});
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h, required 0", rsp_rdata);
        end
        checks++;
        if ({bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_wmask} !== 69'h0) begin
            errors++;
            $display("FAIL reset_payload: we=%b addr=%h wdata=%h wmask=%b, required all 0",
                     bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_wmask);
        end
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got %b with req_valid=1, required 1", stall);
        end
        repeat (3) @(posedge clk);
        // Nothing may have been captured while reset is held.
        checks++;
        if (bus.bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: bus_valid=%b, required 0", bus.bus_valid);
        end
        req_valid = 1'b0;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store;
        int lat;
        issue(1'b1, 32'h0000_0104, 32'hAABB_CCDD, 4'b0011, 0, 0, 32'h0, 1'b1, 1'b0, lat);
        check_lat("store_latency", lat, 3);
        idle_cycles(1);
    endtask

    task automatic test_load;
        int lat;
        int nr;
        nr = n_rsp;
        issue(1'b0, 32'h0000_0203, 32'h1111_2222, 4'hF, 2, 2, 32'h1234_5678, 1'b1, 1'b0, lat);
        check_lat("load_latency", lat, 8);
        idle_cycles(3);
        checks++;
        if (rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL load_rdata_hold: got %h, required 12345678", rsp_rdata);
        end
        checks++;
        if (n_rsp - nr !== 1) begin
            errors++;
            $display("FAIL load_rsp_count: got %0d responses, required 1", n_rsp - nr);
        end
    endtask

    task automatic test_min_load;
        int lat;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'hCAFE_F00D, 1'b1, 1'b0, lat);
        check_lat("load_min_latency", lat, 4);
        idle_cycles(1);
    endtask

    task automatic test_zero_mask_store;
        int lat;
        int nb;
        nb = n_bus;
        issue(1'b1, 32'h0000_0007, 32'h0102_0304, 4'h0, 0, 0, 32'h0, 1'b1, 1'b0, lat);
        check_lat("zero_mask_latency", lat, 3);
        idle_cycles(2);
        checks++;
        if (n_bus - nb !== 1) begin
            errors++;
            $display("FAIL zero_mask_handshake: got %0d bus txns, required 1", n_bus - nb);
        end
        checks++;
        if (rsp_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL store_keeps_rdata: got %h, required cafef00d", rsp_rdata);
        end
    endtask

`ifndef MEM_ACCESS_TIMEOUT_EN
    task automatic test_long_wait;
        int lat;
        issue(1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'b1010, 20, 0, 32'h0, 1'b1, 1'b0, lat);
        check_lat("long_wait_latency", lat, 23);
        idle_cycles(1);
    endtask
`endif

    task automatic test_back_to_back;
        int lat;
        int nb;
        int nr;
        nb = n_bus;
        nr = n_rsp;
        issue(1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, 1, 32'h0A0B_0C0D, 1'b1, 1'b0, lat);
        check_lat("b2b_load_latency", lat, 5);
        issue(1'b1, 32'h0000_0408, 32'hF00D_BABE, 4'b1100, 0, 0, 32'h0, 1'b1, 1'b0, lat);
        check_lat("b2b_store_latency", lat, 3);
        idle_cycles(4);
        checks++;
        if (n_bus - nb !== 2) begin
            errors++;
            $display("FAIL b2b_bus_count: got %0d bus txns, required 2", n_bus - nb);
        end
        checks++;
        if (n_rsp - nr !== 2) begin
            errors++;
            $display("FAIL b2b_rsp_count: got %0d responses, required 2", n_rsp - nr);
        end
        checks++;
        if (bus.bus_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: bus_valid=%b stall=%b, required 0 0", bus.bus_valid, stall);
        end
    endtask

    task automatic test_reset_mid;
        bus_txn_t eb;
        int       nr;
        int       nb;
        int       cyc;
        int       lat;
        cfg_ready_wait  = 0;
        cfg_rvalid_wait = 4;
        cfg_rdata       = 32'h55AA_55AA;
        eb = {1'b0, 32'h0000_0300, 32'h7777_7777, 4'h0};
        exp_bus_q.push_back(eb);
        nb = n_bus;
        nr = n_rsp;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0301;
        req_wdata = 32'h7777_7777;
        req_wmask = 4'h3;
        cyc = 0;
        while (n_bus == nb && cyc < WAIT_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (n_bus == nb) begin
            errors++;
            $display("FAIL reset_mid_issue: no bus handshake within %0d cycles", WAIT_LIMIT);
        end
        // Now in WAIT_R: reset mid-cycle, away from any clock edge.
        @(posedge clk);
        #3;
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        checks++;
        if ({bus.bus_valid, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0 || bus.bus_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: bus_valid=%b rsp_valid=%b rsp_err=%b rdata=%h addr=%h, required all 0",
                     bus.bus_valid, rsp_valid, rsp_err, rsp_rdata, bus.bus_addr);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst          = 1'b0;
        model_rdata  = 32'h0;
        stray_rvalid = 2;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (n_rsp !== nr) begin
            errors++;
            $display("FAIL reset_no_rsp: got %0d responses after reset, required 0", n_rsp - nr);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || bus.bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_late_rvalid: rdata=%h bus_valid=%b, required 0 0", rsp_rdata, bus.bus_valid);
        end
        issue(1'b0, 32'h0000_020C, 32'h0, 4'h0, 0, 0, 32'h0BAD_BEEF, 1'b1, 1'b0, lat);
        check_lat("post_reset_load_latency", lat, 4);
        idle_cycles(1);
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout;
        int lat;
        int nb;
        nb = n_bus;
        issue(1'b1, 32'h0000_0500, 32'h1357_9BDF, 4'hF, 1000, 0, 32'h0, 1'b0, 1'b1, lat);
        check_lat("timeout_req_latency", lat, 6);
        idle_cycles(3);
        checks++;
        if (bus.bus_valid !== 1'b0 || n_bus !== nb) begin
            errors++;
            $display("FAIL timeout_valid_drop: bus_valid=%b txns=%0d, required 0 0", bus.bus_valid, n_bus - nb);
        end
        issue(1'b0, 32'h0000_0600, 32'h0, 4'h0, 0, 1000, 32'h9999_9999, 1'b1, 1'b1, lat);
        check_lat("timeout_wait_r_latency", lat, 7);
        idle_cycles(2);
    endtask

    task automatic test_timeout_race;
        int lat;
        issue(1'b1, 32'h0000_0700, 32'h2468_ACE0, 4'b0101, 3, 0, 32'h0, 1'b1, 1'b0, lat);
        check_lat("timeout_race_latency", lat, 6);
        idle_cycles(2);
    endtask
`endif

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_store();
        test_load();
        test_min_load();
        test_zero_mask_store();
`ifndef MEM_ACCESS_TIMEOUT_EN
        test_long_wait();
`endif
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_ACCESS_TIMEOUT_EN
        test_timeout();
        test_timeout_race();
`endif
        checks++;
        if (exp_bus_q.size() != 0 || exp_rsp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bus txns and %0d responses never seen",
                     exp_bus_q.size(), exp_rsp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, is the bus wait-cycle limit used only when MEM_ACCESS_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous and active-high.
REQ-004 Port: req_valid  in  1  core load/store request present this cycle.
REQ-005 Port: req_we  in  1  1 = store, 0 = load.
REQ-006 Port: req_addr  in  32  byte address from the core.
REQ-007 Port: req_wdata  in  32  store data, already lane-replicated by the formatter.
REQ-008 Port: req_wmask  in  4  byte-lane write mask from the formatter.
REQ-009 Port: stall  out  1  holds the core PC and pipeline while high.
REQ-010 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 Port: rsp_rdata  out  32  raw memory word, consumed by the load formatter as its unshifted read value.
REQ-012 Port: rsp_err  out  1  access aborted on timeout; valid only with rsp_valid.
REQ-013 Port: bus_valid / bus_ready  out / in  1 / 1  request handshake to the memory.
REQ-014 Port: bus_we, bus_addr, bus_wdata, bus_wmask  out  1, 32, 32, 4  bus request payload.
REQ-015 Port: bus_rvalid / bus_rdata  in / in  1 / 32  read response from the memory.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, REQ, WAIT_R and DONE.
- IDLE -> REQ when req_valid=1; all request fields are captured at that edge.
REQ-017 In REQ: bus_valid=1 and the payload is driven from the captured registers.
- bus_addr = {addr[31:2], 2'b00}.
- Payload stays stable until bus_ready=1 (valid SHALL NOT drop before ready).
REQ-018 REQ with bus_ready=1: store -> DONE, load -> WAIT_R.
REQ-019 In WAIT_R: bus_rvalid=1 captures bus_rdata into rsp_rdata and moves to DONE.
- bus_rvalid is ignored in every state other than WAIT_R.
REQ-020 In DONE: rsp_valid=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-021 stall = req_valid AND (state != DONE), combinational.
- The core advances on the DONE edge.
- The request seen in IDLE on the following cycle is treated as new.
REQ-022 Minimum latency:
- Store: 3 cycles, req_valid to rsp_valid, with bus_ready=1 immediately.
- Load: 4 cycles, with bus_rvalid=1 on the first WAIT_R cycle.
REQ-023 rsp_rdata holds its last captured value until the next load completes; stores leave it unchanged.
REQ-024 For a store, bus_wmask = captured mask. For a load, bus_wmask = 4'h0.
REQ-025 A store with wmask=0 SHALL still complete the bus handshake; no write is suppressed.
REQ-026 bus_valid, rsp_valid and rsp_err SHALL be 0 in IDLE, WAIT_R and REQ, except where stated above.

Reset
REQ-027 rst=1 immediately forces:
- state=IDLE;
- bus_valid=0, rsp_valid=0, rsp_err=0;
- rsp_rdata=0 and all capture registers=0;
- timeout counter=0.
REQ-028 Reset mid-transaction abandons the access with no response; a late bus_rvalid after reset is ignored.

Configuration
REQ-029 Macro MEM_ACCESS_TIMEOUT_EN, when defined:
- An 8-bit counter clears on entry to REQ or WAIT_R and increments each cycle spent there.
- When the counter reaches TIMEOUT_CYCLES-1 without the awaited handshake: -> DONE with rsp_err=1, bus_valid deasserted, rsp_rdata unchanged.
- A handshake arriving on that same cycle wins and rsp_err=0.
REQ-030 Without MEM_ACCESS_TIMEOUT_EN: no counter exists, rsp_err is tied to 0, and REQ/WAIT_R wait indefinitely.

Verification
REQ-031 Store, addr=0x104, wdata=0xAABBCCDD, mask=4'b0011, ready immediate:
- bus_addr=0x104, bus_wmask=0011;
- rsp_valid on cycle 3, stall low in that cycle.
REQ-032 Load, addr=0x203, ready after 2 wait cycles, rvalid 3 cycles later with 0x12345678:
- bus_addr=0x200, bus_wmask=0;
- rsp_rdata=0x12345678, rsp_valid once.
REQ-033 Back-to-back load then store, req_valid held high:
- Exactly two bus transactions, no duplicate issue;
- stall low only in the two DONE cycles.
REQ-034 Reset asserted in WAIT_R, then rvalid pulses:
- Outputs 0 asynchronously;
- no rsp_valid;
- the next request behaves normally.
REQ-035 With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus_ready held 0:
- rsp_valid=1 and rsp_err=1 on the 4th REQ-state cycle plus 1;
- bus_valid=0 afterwards.
REQ-036 Same case with ready=1 on the limit cycle:
- normal completion, rsp_err=0.
